fe_tobytes_seq: RTL and testbench
=================================

Name: fe_tobytes_seq

Overview:
Parametrised, multi-cycle GF(2^255-19) field-element-to-bytes converter for the ed25519 datapath.
- Takes a 10-limb signed radix-2^25.5 field element and produces its canonical 32-byte little-endian encoding (fully reduced mod p).
- Throughput vs area is set by carry-chain unrolling (STEPS).
- Output is either one 256-bit word or a 32-beat byte stream with backpressure.

Parameters:
STEPS, 1, carry-chain steps per cycle; legal values 1, 2, 5, 10.
OUT_W, 256, output width; 256 = parallel word, 8 = byte-serial stream.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in  in  320  limbs h0..h9, 32-bit two's complement each; h_i = in[32i+31:32i]
valid  in  1  input strobe; accepted only when ready=1
ready  out  1  high in IDLE only
out  out  OUT_W  result (parallel) or current byte s[k] (serial)
done  out  1  out is valid; held until ack
ack  in  1  consumer takes out in any cycle where done=1 and ack=1
last  out  1  serial: done on byte s[31]; parallel: equals done

Behaviour:
- Reset values: ready=0 during the reset cycle, then 1. done=0, last=0, out=0, all limb/q registers 0, state=IDLE.
- Reset in any state aborts the operation; no partial result is emitted.
- States and transitions:
  - IDLE -> LOAD on valid&ready. Limbs are registered.
  - LOAD: computes q = (19*h9 + 2^24) >>> 25 (signed arithmetic).
  - QCHAIN: runs ceil(10/STEPS) cycles. Each cycle applies STEPS of: q = (h_i + q) >>> w_i, for i=0..9 in order. w_i = 26 for even i, 25 for odd i.
  - CARRY: runs ceil(10/STEPS) cycles.
    - First CARRY cycle begins with h0 += 19*q.
    - Each step for i=0..8: c = h_i >>> w_i; h_{i+1} += c; h_i -= c << w_i.
    - Step i=9: h9 -= (h9 >>> 25) << 25; the carry out of h9 is discarded.
  - PACK (1 cycle): packs 255 bits.
    - Limb i occupies bits starting at offset 0,26,51,77,102,128,153,179,204,230 for i=0..9.
    - Bit 255 = 0.
    - Byte s[k] = bits 8k+7:8k.
  - OUTPUT: done=1.
- Internal arithmetic: limbs are 32-bit signed; 19*h9 and 19*q use a 37-bit intermediate. Shifts are arithmetic.
- Latency, valid accepted to first done=1: 2*ceil(10/STEPS)+2 cycles. STEPS=1: 22; STEPS=10: 4.
- Parallel mode (OUT_W=256):
  - out = {s[31],...,s[0]}.
  - done and out are held stable while ack=0.
  - done&ack -> IDLE next cycle.
- Serial mode (OUT_W=8):
  - 5-bit beat counter k starts at 0; out = s[k].
  - Each done&ack increments k. The beat with k=31 asserts last.
  - done&ack&last -> IDLE.
  - out is stable while ack=0.
- ready=0 in every state except IDLE. valid while ready=0 is ignored and not queued. There is one bubble cycle between the final ack and the next accept.
- ack while done=0 is ignored.
- Inputs outside ref10 limb bounds give an undefined value, but done must still assert at the stated latency.

Optional Feature:
Macro FE_TOBYTES_NONCANON_EN.
- Defined:
  - Extra output port noncanon (1 bit), reset 0.
  - Equals the final QCHAIN q bit (1 when the input value is >= p after reduction, i.e. the encoding required subtracting p).
  - Valid with done; held until the final ack.
- Undefined: the port is absent and no q register is retained past CARRY.
- Result bytes are identical in both builds.

Test Plan:
- STEPS=1, OUT_W=256, in=320'hff348211fef50137006a7aa9014d6f3f00fe8356fe5600a000dfcc46019732a5ff5135d600c4b8ae -> out=256'h4d20842f50137353d54a9ade7efe83559580281bf988ccb9952544d758c4b89b, done exactly 22 cycles after accept.
- in=0 -> out=0. in=p (h0=0x3ffffed, odd limbs 0x1ffffff, other even limbs 0x3ffffff) -> out=0, noncanon=1. in=p with h0=0x3ffffee -> out=1.
- STEPS=10, the first vector -> same out, done 4 cycles after accept. Hold ack=0 for 5 cycles -> done and out stable, ready=0.
- OUT_W=8, the first vector -> 32 beats: first 0x9b, then 0xb8, ...; final 0x4d with last=1. Random ack gaps: no beat lost or duplicated.
- Reset asserted in QCHAIN mid-operation -> next cycle done=0, out=0, ready=1. A fresh vector then completes correctly.
- valid pulsed while busy -> ignored. Only the first operand's result is produced.

Source files
------------

// File: rtl/fe_tobytes_seq_if.sv
// Request/response bundle for fe_tobytes_seq.
// The noncanon signal exists only when FE_TOBYTES_NONCANON_EN is defined.
interface fe_tobytes_seq_if #(parameter int OUT_W = 256);
  logic [319:0]     in;
  logic             valid, ready, done, ack, last;
  logic [OUT_W-1:0] out;
`ifdef FE_TOBYTES_NONCANON_EN
  logic             noncanon;
  modport master (output in, valid, ack, input ready, out, done, last, noncanon);
  modport slave  (input in, valid, ack, output ready, out, done, last, noncanon);
`else
  modport master (output in, valid, ack, input ready, out, done, last);
  modport slave  (input in, valid, ack, output ready, out, done, last);
`endif
endinterface

// File: rtl/fe_tobytes_seq.sv
// Multi-cycle GF(2^255-19) limb-to-canonical-bytes converter (ref10 tobytes).
// Optional macro FE_TOBYTES_NONCANON_EN adds the noncanon output (final q bit).
module fe_tobytes_seq #(
  parameter int STEPS = 1,
  parameter int OUT_W = 256
) (
  input  logic            clk,
  input  logic            rst,
  fe_tobytes_seq_if.slave bus
);
  localparam int NCYC = (10 + STEPS - 1) / STEPS;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_QCHAIN, S_CARRY, S_PACK, S_OUT} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] h_q [10];
  logic signed [31:0] h_d [10];
  logic signed [31:0] q_q, q_d, qt, c;
  logic [3:0]         cnt_q, cnt_d;
  logic [255:0]       s_q, s_d;
  logic [4:0]         k_q, k_d;
  logic               last_beat, fire, last_cyc;
  int                 base;

  assign fire     = bus.done & bus.ack;
  assign last_cyc = (cnt_q == 4'(NCYC - 1));
  assign base     = int'(cnt_q) * STEPS;

  if (OUT_W == 8) begin : g_ser
    assign bus.out   = s_q[{k_q, 3'b000} +: 8];
    assign last_beat = (k_q == 5'd31);
  end else begin : g_par
    assign bus.out   = s_q;
    assign last_beat = 1'b1;
  end

  assign bus.ready = (state_q == S_IDLE) & ~rst;
  assign bus.done  = (state_q == S_OUT);
  assign bus.last  = bus.done & last_beat;

`ifdef FE_TOBYTES_NONCANON_EN
  logic nc_q, nc_d;
  assign bus.noncanon = nc_q;
`endif

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    k_d     = k_q;
    qt      = q_q;
    c       = '0;
`ifdef FE_TOBYTES_NONCANON_EN
    nc_d    = nc_q;
`endif
    case (state_q)
      S_IDLE: if (bus.valid) begin
        for (int i = 0; i < 10; i++) h_d[i] = bus.in[32*i +: 32];
        k_d     = '0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        // 37-bit product keeps 19*h9 exact before the rounding shift
        q_d     = 32'(($signed({{5{h_q[9][31]}}, h_q[9]}) * 37'sd19 + 37'sd16777216) >>> 25);
        cnt_d   = '0;
        state_d = S_QCHAIN;
      end
      S_QCHAIN: begin
        for (int i = 0; i < 10; i++)
          if (i >= base && i < base + STEPS)
            qt = (i % 2 == 1) ? ((h_q[i] + qt) >>> 25) : ((h_q[i] + qt) >>> 26);
        q_d   = qt;
        cnt_d = last_cyc ? 4'd0 : cnt_q + 4'd1;
        if (last_cyc) state_d = S_CARRY;
      end
      S_CARRY: begin
        // only the low 32 bits of 19*q can reach the limb
        if (cnt_q == 4'd0) h_d[0] = h_q[0] + q_q * 32'sd19;
        for (int i = 0; i < 9; i++)
          if (i >= base && i < base + STEPS) begin
            c        = (i % 2 == 1) ? (h_d[i] >>> 25) : (h_d[i] >>> 26);
            h_d[i+1] = h_d[i+1] + c;
            h_d[i]   = h_d[i] - ((i % 2 == 1) ? (c <<< 25) : (c <<< 26));
          end
        if (9 >= base && 9 < base + STEPS) h_d[9] = h_d[9] - ((h_d[9] >>> 25) <<< 25);
        cnt_d = last_cyc ? 4'd0 : cnt_q + 4'd1;
        if (last_cyc) state_d = S_PACK;
      end
      S_PACK: begin
        s_d = '0;
        for (int i = 0; i < 10; i++)
          s_d = s_d | (256'({(i % 2 == 0) & h_q[i][25], h_q[i][24:0]}) << (25*i + (i+1)/2));
`ifdef FE_TOBYTES_NONCANON_EN
        nc_d = q_q[0];
`endif
        state_d = S_OUT;
      end
      S_OUT: if (fire) begin
        if (last_beat) begin
          state_d = S_IDLE;
          k_d     = '0;
`ifdef FE_TOBYTES_NONCANON_EN
          nc_d    = 1'b0;
`endif
        end else begin
          k_d = k_q + 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= '{default: '0};
      q_q     <= '0;
      cnt_q   <= '0;
      s_q     <= '0;
      k_q     <= '0;
`ifdef FE_TOBYTES_NONCANON_EN
      nc_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      k_q     <= k_d;
`ifdef FE_TOBYTES_NONCANON_EN
      nc_q    <= nc_d;
`endif
    end
  end
endmodule

// File: tb/tb_fe_tobytes_seq.sv
// Scoreboard bench: three builds (STEPS=1/256b, STEPS=10/256b, STEPS=2/byte stream) fed in lockstep.
module tb_fe_tobytes_seq;
  typedef struct { logic [255:0] s; bit ncv; bit nc; } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  int           n_chk = 0, n_err = 0, cyc = 0, t_acc = 0, ks = 0;
  bit           ack_en = 1'b0;
  bit           d1_prev = 1'b0, d10_prev = 1'b0, ds_prev = 1'b0;
  exp_t         q1[$], q10[$], qs[$];
  exp_t         e1, e10, es;
  logic [319:0] v0, vx;
  logic [255:0] s0;
  exp_t         ex;

  fe_tobytes_seq_if #(.OUT_W(256)) b1 ();
  fe_tobytes_seq_if #(.OUT_W(256)) b10 ();
  fe_tobytes_seq_if #(.OUT_W(8))   bs ();

  fe_tobytes_seq #(.STEPS(1),  .OUT_W(256)) u_p1  (.clk(clk), .rst(rst), .bus(b1));
  fe_tobytes_seq #(.STEPS(10), .OUT_W(256)) u_p10 (.clk(clk), .rst(rst), .bus(b10));
  fe_tobytes_seq #(.STEPS(2),  .OUT_W(8))   u_s   (.clk(clk), .rst(rst), .bus(bs));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference: evaluate the limb sum as an integer and reduce it mod p directly.
  function automatic exp_t model(input logic [319:0] x);
    logic signed [319:0] v, p;
    exp_t e;
    p = {64'd0, 256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed};
    v = '0;
    for (int i = 0; i < 10; i++)
      v = v + ($signed({{288{x[32*i+31]}}, x[32*i +: 32]}) <<< (25*i + (i+1)/2));
    e.ncv = (v >= 0) && (v < (p <<< 1));
    e.nc  = (v >= p);
    while (v < 0) v = v + p;
    while (v >= p) v = v - p;
    e.s = v[255:0];
    return e;
  endfunction

  function automatic logic [319:0] mkp(input logic [31:0] h0);
    logic [319:0] x;
    x[31:0] = h0;
    for (int i = 1; i < 10; i++) x[32*i +: 32] = (i % 2 == 1) ? 32'h1ffffff : 32'h3ffffff;
    return x;
  endfunction

  function automatic logic [319:0] rnd_vec();
    logic [319:0] x;
    int h;
    for (int i = 0; i < 10; i++) begin
      h = (i % 2 == 0) ? int'($urandom_range(0, 67108863)) - 33554432
                       : int'($urandom_range(0, 33554431)) - 16777216;
      x[32*i +: 32] = h;
    end
    return x;
  endfunction

  task automatic send(input logic [319:0] x, input exp_t e);
    int n = 0;
    while (!(b1.ready && b10.ready && bs.ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 256'(n < 300), 256'd1);
    b1.in = x; b10.in = x; bs.in = x;
    b1.valid = 1'b1; b10.valid = 1'b1; bs.valid = 1'b1;
    t_acc = cyc + 1;
    q1.push_back(e); q10.push_back(e); qs.push_back(e);
    @(negedge clk);
    b1.valid = 1'b0; b10.valid = 1'b0; bs.valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() + q10.size() + qs.size()) != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 256'(n < 3000), 256'd1);
  endtask

  always @(posedge clk) begin
    #1;
    b1.ack  = ack_en & ($urandom_range(0, 3) != 0);
    b10.ack = ack_en & ($urandom_range(0, 3) != 0);
    bs.ack  = ack_en & ($urandom_range(0, 2) != 0);
  end

  always @(negedge clk) begin
    if (rst) begin
      ks = 0;
    end else begin
      if (b1.done && !d1_prev)  chk("lat_p1",  256'(cyc - t_acc), 256'd22);
      if (b10.done && !d10_prev) chk("lat_p10", 256'(cyc - t_acc), 256'd4);
      if (bs.done && !ds_prev)  chk("lat_s",   256'(cyc - t_acc), 256'd12);
      if (b1.done && b1.ack) begin
        chk("sb_p1", 256'(q1.size() != 0), 256'd1);
        if (q1.size() != 0) begin
          e1 = q1.pop_front();
          chk("out_p1", b1.out, e1.s);
          chk("last_p1", 256'(b1.last), 256'd1);
`ifdef FE_TOBYTES_NONCANON_EN
          if (e1.ncv) chk("nc_p1", 256'(b1.noncanon), 256'(e1.nc));
`endif
        end
      end
      if (b10.done && b10.ack) begin
        chk("sb_p10", 256'(q10.size() != 0), 256'd1);
        if (q10.size() != 0) begin
          e10 = q10.pop_front();
          chk("out_p10", b10.out, e10.s);
`ifdef FE_TOBYTES_NONCANON_EN
          if (e10.ncv) chk("nc_p10", 256'(b10.noncanon), 256'(e10.nc));
`endif
        end
      end
      if (bs.done && bs.ack) begin
        chk("sb_s", 256'(qs.size() != 0), 256'd1);
        if (qs.size() != 0) begin
          es = qs[0];
          chk("byte_s", 256'(bs.out), 256'(es.s[8*ks +: 8]));
          chk("last_s", 256'(bs.last), 256'(ks == 31));
          if (ks == 31) begin
            void'(qs.pop_front());
            ks = 0;
          end else begin
            ks++;
          end
        end
      end
    end
    d1_prev = b1.done; d10_prev = b10.done; ds_prev = bs.done;
  end

  initial begin
    v0 = 320'hff348211fef50137006a7aa9014d6f3f00fe8356fe5600a000dfcc46019732a5ff5135d600c4b8ae;
    s0 = 256'h4d20842f50137353d54a9ade7efe83559580281bf988ccb9952544d758c4b89b;
    b1.valid = 1'b0; b10.valid = 1'b0; bs.valid = 1'b0;
    b1.in = '0; b10.in = '0; bs.in = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 256'({b1.ready, b10.ready, bs.ready}), 256'd0);
    chk("rst_done", 256'({b1.done, b10.done, bs.done}), 256'd0);
    chk("rst_last", 256'({b1.last, b10.last, bs.last}), 256'd0);
    chk("rst_out", b1.out | b10.out | 256'(bs.out), 256'd0);
`ifdef FE_TOBYTES_NONCANON_EN
    chk("rst_nc", 256'({b1.noncanon, b10.noncanon, bs.noncanon}), 256'd0);
`endif
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 256'({b1.ready, b10.ready, bs.ready}), 256'd7);
    @(negedge clk);
    ack_en = 1'b1;

    // reference vector, then a valid pulse while busy that must be dropped
    ex = '{s0, 1'b0, 1'b0};
    send(v0, ex);
    b1.in = mkp(32'h3ffffed); b10.in = b1.in; bs.in = b1.in;
    b1.valid = 1'b1; b10.valid = 1'b1; bs.valid = 1'b1;
    repeat (2) @(negedge clk);
    b1.valid = 1'b0; b10.valid = 1'b0; bs.valid = 1'b0;

    ex = '{256'd0, 1'b1, 1'b0}; send('0, ex);
    ex = '{256'd0, 1'b1, 1'b1}; send(mkp(32'h3ffffed), ex);
    ex = '{256'd1, 1'b1, 1'b1}; send(mkp(32'h3ffffee), ex);
    for (int n = 0; n < 4; n++) begin
      vx = rnd_vec();
      send(vx, model(vx));
    end
    drain();

    // ack withheld: result must stay put and the block stays busy
    ack_en = 1'b0;
    @(negedge clk);
    ex = '{s0, 1'b0, 1'b0};
    send(v0, ex);
    repeat (30) @(negedge clk);
    for (int n = 0; n < 5; n++) begin
      chk("hold_done", 256'({b1.done, b10.done, bs.done}), 256'd7);
      chk("hold_ready", 256'({b1.ready, b10.ready, bs.ready}), 256'd0);
      chk("hold_out_p1", b1.out, s0);
      chk("hold_out_p10", b10.out, s0);
      chk("hold_out_s", 256'(bs.out), 256'(s0[7:0]));
      @(negedge clk);
    end
    ack_en = 1'b1;
    drain();

    // reset mid-operation aborts everything
    vx = rnd_vec();
    send(vx, model(vx));
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_done", 256'({b1.done, b10.done, bs.done}), 256'd0);
    chk("abort_out", b1.out | b10.out | 256'(bs.out), 256'd0);
    chk("abort_ready_in_rst", 256'({b1.ready, b10.ready, bs.ready}), 256'd0);
    q1.delete(); q10.delete(); qs.delete();
    rst = 1'b0;
    #1;
    chk("abort_ready", 256'({b1.ready, b10.ready, bs.ready}), 256'd7);
    @(negedge clk);
    ex = '{s0, 1'b0, 1'b0};
    send(v0, ex);
    vx = rnd_vec();
    send(vx, model(vx));
    drain();
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got %0d want finish", cyc);
    $fatal(1);
  end
endmodule
